// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider (DIV / DIVU / REM / REMU)
//
// Restoring shift-subtract divider: one quotient bit per clock, 32 iterations.
// Divide-by-zero and signed overflow bypass the iteration and complete in one
// cycle. Signed operations divide magnitudes and fix the signs at the end.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request a divide (sampled only while busy=0)
//   op       in   00=DIV 01=DIVU 10=REM 11=REMU
//   rs1_data in   dividend
//   rs2_data in   divisor
//   rd_in    in   destination register index, captured with start
//   kill     in   pipeline flush, aborts any in-flight operation
//   busy     out  operation in progress
//   wb_en    out  one-cycle write-back strobe
//   wb_data  out  result, held while wb_en=0
//   rd_index out  destination index, held while wb_en=0
//
// Handshake: start is a request accepted on any rising edge where busy=0,
// start=1 and kill=0; the result is offered by a single wb_en pulse with no
// back-pressure (the register file always accepts it).
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            wb_en,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_index
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] quot_q, quot_d;       // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] rem_q, rem_d;         // partial remainder
    logic [XLEN-1:0] dvsr_q, dvsr_d;       // divisor magnitude
    logic [4:0]      cnt_q, cnt_d;         // iteration counter
    logic [4:0]      rd_q, rd_d;           // captured destination
    logic            rem_sel_q, rem_sel_d; // 1: return remainder
    logic            qneg_q, qneg_d;       // negate quotient at the end
    logic            rneg_q, rneg_d;       // negate remainder at the end
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      rd_index_q, rd_index_d;

    // Operand decode for a new request
    logic            is_signed, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign is_signed   = ~op[0];
    assign a_neg       = is_signed & rs1_data[XLEN-1];
    assign b_neg       = is_signed & rs2_data[XLEN-1];
    assign a_mag       = a_neg ? -rs1_data : rs1_data;
    assign b_mag       = b_neg ? -rs2_data : rs2_data;
    assign div_zero    = (rs2_data == '0);
    assign overflow    = is_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                                   && (rs2_data == '1);
    // Divide-by-zero: quotient all ones, remainder = dividend.
    // Overflow: quotient = most negative value, remainder = 0.
    assign special_res = div_zero ? (op[1] ? rs1_data : '1)
                                  : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One restoring iteration: bring in the next dividend bit, try to subtract.
    logic [XLEN:0]   shifted, diff;
    logic            fits;
    logic [XLEN-1:0] step_rem, step_quot, fin_quot, fin_rem;

    assign shifted   = {rem_q, quot_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvsr_q};
    assign fits      = ~diff[XLEN];
    assign step_rem  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign step_quot = {quot_q[XLEN-2:0], fits};
    assign fin_quot  = qneg_q ? -step_quot : step_quot;
    assign fin_rem   = rneg_q ? -step_rem : step_rem;

    always_comb begin
        state_d    = state_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rem_sel_d  = rem_sel_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        wb_data_d  = wb_data_q;
        rd_index_d = rd_index_q;

        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    rd_d      = rd_in;
                    rem_sel_d = op[1];
                    if (div_zero || overflow) begin
                        wb_data_d  = special_res;
                        rd_index_d = rd_in;
                        state_d    = S_DONE;
                    end else begin
                        quot_d  = a_mag;
                        rem_d   = '0;
                        dvsr_d  = b_mag;
                        cnt_d   = 5'd0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;   // remainder follows the dividend
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quot_d = step_quot;
                rem_d  = step_rem;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    wb_data_d  = rem_sel_q ? fin_rem : fin_quot;
                    rd_index_d = rd_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush wins over everything and must not disturb the held outputs.
        if (kill) begin
            state_d    = S_IDLE;
            wb_data_d  = wb_data_q;
            rd_index_d = rd_index_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            quot_q     <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            rem_sel_q  <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            wb_data_q  <= '0;
            rd_index_q <= '0;
        end else begin
            state_q    <= state_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rem_sel_q  <= rem_sel_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            wb_data_q  <= wb_data_d;
            rd_index_q <= rd_index_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    // A flush in the DONE cycle cancels the write-back.
    assign wb_en    = (state_q == S_DONE) && !kill;
    assign wb_data  = wb_data_q;
    assign rd_index = rd_index_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// Directed cases, flush/reset interruptions, then random operations checked
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  rd_index;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .kill(kill),
    .busy(busy), .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit ref_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (o[0]) return o[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;   // truncates toward zero
    r = sa % sb;   // sign of dividend
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request and let edge N sample it.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called at the sample after edge N+elapsed; finds the first wb_en pulse.
  task automatic wait_wb(input int elapsed, input bit special, input logic [31:0] exp_data,
                         input logic [4:0] exp_rd, input string tag);
    int k;
    int exp_lat;
    exp_lat = special ? 0 : 32;
    k = elapsed;
    while (wb_en !== 1'b1 && k < exp_lat + 8) begin
      step();
      k++;
    end
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " data"}, wb_data, exp_data);
    chk({tag, " rd"}, {27'd0, rd_index}, {27'd0, exp_rd});
    step();
    chk({tag, " wb_en drop"}, {31'd0, wb_en}, 32'd0);
    chk({tag, " busy drop"}, {31'd0, busy}, 32'd0);
    chk({tag, " hold"}, wb_data, exp_data);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    issue(o, a, b, rd);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_wb(0, ref_special(o, a, b), ref_div(o, a, b), rd, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held;
    int          seen;

    // reset
    rst_n = 1'b0;
    step(); step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset wb_en", {31'd0, wb_en}, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset rd_index", {27'd0, rd_index}, 32'd0);
    rst_n = 1'b1;
    step();

    // directed values
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, "divu 100/7");
    chk("divu 100/7 const", wb_data, 32'd14);
    run_op(OP_REMU, 32'd100, 32'd7, 5'd5, "remu 100/7");
    chk("remu 100/7 const", wb_data, 32'd2);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, "div -7/2");
    chk("div -7/2 const", wb_data, 32'hFFFF_FFFD);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, "rem -7/2");
    chk("rem -7/2 const", wb_data, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3, "div 7/-2");
    chk("div 7/-2 const", wb_data, 32'hFFFF_FFFD);
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, "rem 7/-2");
    chk("rem 7/-2 const", wb_data, 32'd1);
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd6, "divu 5/0");
    chk("divu 5/0 const", wb_data, 32'hFFFF_FFFF);
    run_op(OP_REM, 32'd5, 32'd0, 5'd7, "rem 5/0");
    chk("rem 5/0 const", wb_data, 32'd5);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "div ovf");
    chk("div ovf const", wb_data, 32'h8000_0000);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "rem ovf");
    chk("rem ovf const", wb_data, 32'd0);
    run_op(OP_DIVU, 32'd42, 32'd6, 5'd0, "rd x0");

    // start while busy is ignored; start right after DONE is accepted
    issue(OP_DIVU, 32'd1000, 32'd10, 5'd11);
    repeat (4) step();
    op = OP_REMU; rs1_data = 32'd77; rs2_data = 32'd0; rd_in = 5'd22; start = 1'b1;
    step();
    start = 1'b0;
    wait_wb(5, 1'b0, 32'd100, 5'd11, "ignored start");
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd12, "back to back");

    // kill in CALC
    held = ref_div(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    issue(OP_DIVU, 32'd12345, 32'd17, 5'd13);
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_en === 1'b1) seen++;
      step();
    end
    chk("kill no wb", seen, 32'd0);
    chk("kill hold data", wb_data, held);
    chk("kill hold rd", {27'd0, rd_index}, 32'd12);
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd14, "after kill");
    chk("after kill const", wb_data, 32'd3);

    // kill has priority over start in IDLE
    op = OP_DIVU; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd15;
    start = 1'b1; kill = 1'b1;
    step();
    start = 1'b0; kill = 1'b0;
    chk("kill over start", {31'd0, busy}, 32'd0);

    // reset mid-operation
    issue(OP_DIV, 32'd999, 32'd3, 5'd16);
    repeat (19) step();
    rst_n = 1'b0;
    start = 1'b1; kill = 1'b1;
    step();
    start = 1'b0; kill = 1'b0;
    rst_n = 1'b1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset wb_en", {31'd0, wb_en}, 32'd0);
    chk("midreset wb_data", wb_data, 32'd0);
    chk("midreset rd_index", {27'd0, rd_index}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_en === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    chk("midreset quiet", seen, 32'd0);
    run_op(OP_REMU, 32'd1001, 32'd10, 5'd17, "after reset");

    // random operations
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          sel;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = -32'($urandom_range(1, 15));
      else if (sel == 4) ra = 32'($urandom_range(0, 100));
      run_op(ro, ra, rb, 5'($urandom_range(0, 31)), "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
